// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer mode of the digital clock.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t SEC_MAX_ONES = 4'd9;

endpackage

// File: rtl/countdown_timer_if.sv
// Button pulses in, BCD digits and status flags out, between the control logic and the timer.
interface countdown_timer_if;
    import countdown_pkg::*;

    logic tick_1hz;
    logic start_pause;
    logic clear;
    logic inc_min;
    logic inc_sec;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic running;
    logic alarm;
    logic done;

    modport master (
        output tick_1hz, start_pause, clear, inc_min, inc_sec,
        input  min_tens, min_ones, sec_tens, sec_ones, running, alarm, done
    );

    modport slave (
        input  tick_1hz, start_pause, clear, inc_min, inc_sec,
        output min_tens, min_ones, sec_tens, sec_ones, running, alarm, done
    );

endinterface

// File: rtl/bcd_mmss_counter.sv
// Four BCD digit registers holding mm:ss, with 1 s decrement and IDLE-mode set increments.
module bcd_mmss_counter
    import countdown_pkg::*;
#(
    parameter int unsigned MAX_MIN = 99
) (
    input  logic clk,
    input  logic reset,
    input  logic dec_i,
    input  logic inc_min_i,
    input  logic inc_sec_i,
    input  logic clr_i,
    output bcd_t min_tens_o,
    output bcd_t min_ones_o,
    output bcd_t sec_tens_o,
    output bcd_t sec_ones_o,
    output logic is_zero_o,
    output logic is_one_o
);

    localparam bcd_t MaxTens = 4'(MAX_MIN / 10);
    localparam bcd_t MaxOnes = 4'(MAX_MIN % 10);

    bcd_t mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clr_i) begin
            mt_d = '0;
            mo_d = '0;
            st_d = '0;
            so_d = '0;
        end else if (dec_i) begin
            // Caller never decrements 00:00, so the minute borrow cannot underflow.
            if (so_q != 4'd0) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = SEC_MAX_ONES;
                if (st_q != 4'd0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = SEC_MAX_TENS;
                    if (mo_q != 4'd0) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        mo_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
        end else begin
            if (inc_min_i) begin
                if (mt_q == MaxTens && mo_q == MaxOnes) begin
                    mt_d = '0;
                    mo_d = '0;
                end else if (mo_q == 4'd9) begin
                    mt_d = mt_q + 4'd1;
                    mo_d = '0;
                end else begin
                    mo_d = mo_q + 4'd1;
                end
            end
            if (inc_sec_i) begin
                if (st_q == SEC_MAX_TENS && so_q == SEC_MAX_ONES) begin
                    st_d = '0;
                    so_d = '0;
                end else if (so_q == SEC_MAX_ONES) begin
                    st_d = st_q + 4'd1;
                    so_d = '0;
                end else begin
                    so_d = so_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens_o = mt_q;
    assign min_ones_o = mo_q;
    assign sec_tens_o = st_q;
    assign sec_ones_o = so_q;
    assign is_zero_o  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign is_one_o   = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer mode: mm:ss set/run/pause FSM with a timed alarm on reaching 00:00.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 10,
    parameter int unsigned MAX_MIN    = 99
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam logic [7:0] AlarmLast = 8'(ALARM_SECS - 1);

    state_t     state_q, state_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       done_q, done_d;
    logic       running_q, alarm_q;
    logic       dec, inc_min, inc_sec, clr;
    logic       is_zero, is_one;

    bcd_mmss_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .dec_i      (dec),
        .inc_min_i  (inc_min),
        .inc_sec_i  (inc_sec),
        .clr_i      (clr),
        .min_tens_o (bus.min_tens),
        .min_ones_o (bus.min_ones),
        .sec_tens_o (bus.sec_tens),
        .sec_ones_o (bus.sec_ones),
        .is_zero_o  (is_zero),
        .is_one_o   (is_one)
    );

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;
        dec         = 1'b0;
        inc_min     = 1'b0;
        inc_sec     = 1'b0;
        clr         = 1'b0;
        if (bus.clear) begin
            clr         = 1'b1;
            state_d     = IDLE;
            alarm_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_pause) begin
                        if (!is_zero) state_d = RUNNING;
                    end else begin
                        inc_min = bus.inc_min;
                        inc_sec = bus.inc_sec;
                    end
                end
                RUNNING: begin
                    // Pause beats a coincident tick, which is simply dropped.
                    if (bus.start_pause) begin
                        state_d = PAUSED;
                    end else if (bus.tick_1hz) begin
                        dec = 1'b1;
                        if (is_one) begin
                            state_d     = EXPIRED;
                            done_d      = 1'b1;
                            alarm_cnt_d = '0;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start_pause) state_d = RUNNING;
                end
                EXPIRED: begin
                    if (bus.start_pause) begin
                        state_d     = IDLE;
                        alarm_cnt_d = '0;
                    end else if (bus.tick_1hz) begin
                        if (alarm_cnt_q == AlarmLast) begin
                            state_d     = IDLE;
                            alarm_cnt_d = '0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            alarm_cnt_q <= '0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
            done_q      <= done_d;
            running_q   <= (state_d == RUNNING);
            alarm_q     <= (state_d == EXPIRED);
        end
    end

    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: set, run, pause, expire, wrap, clear and async reset.
module tb_countdown_timer;
    import countdown_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    countdown_timer_if bus ();

    countdown_timer #(
        .ALARM_SECS (10),
        .MAX_MIN    (99)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Called at a negedge: drive for one posedge, return at the next negedge.
    task automatic step(input logic t, input logic sp, input logic cl, input logic im,
                        input logic is);
        bus.tick_1hz    = t;
        bus.start_pause = sp;
        bus.clear       = cl;
        bus.inc_min     = im;
        bus.inc_sec     = is;
        @(negedge clk);
        bus.tick_1hz    = 1'b0;
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.inc_min     = 1'b0;
        bus.inc_sec     = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] digits();
        return {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        bus.tick_1hz    = 1'b0;
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.inc_min     = 1'b0;
        bus.inc_sec     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_digits", digits(), 32'h0000);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_alarm", 32'(bus.alarm), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 01:05 countdown to expiry, then alarm auto-return.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        check("set_0105", digits(), 32'h0105);
        step(0, 1, 0, 0, 0);
        check("start_running", 32'(bus.running), 32'h1);
        for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 0);
        check("t64_digits", digits(), 32'h0001);
        check("t64_done", 32'(bus.done), 32'h0);
        step(1, 0, 0, 0, 0);
        check("t65_digits", digits(), 32'h0000);
        check("t65_done", 32'(bus.done), 32'h1);
        check("t65_alarm", 32'(bus.alarm), 32'h1);
        check("t65_running", 32'(bus.running), 32'h0);
        step(0, 0, 0, 0, 0);
        check("done_width", 32'(bus.done), 32'h0);
        check("alarm_held", 32'(bus.alarm), 32'h1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        check("alarm_9", 32'(bus.alarm), 32'h1);
        step(1, 0, 0, 0, 0);
        check("alarm_10", 32'(bus.alarm), 32'h0);
        check("alarm_10_digits", digits(), 32'h0000);

        // 00:02 with pause/resume, then acknowledge alarm.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("p_0001", digits(), 32'h0001);
        step(0, 1, 0, 0, 0);
        check("p_paused", 32'(bus.running), 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        check("p_frozen", digits(), 32'h0001);
        check("p_no_alarm", 32'(bus.alarm), 32'h0);
        step(0, 1, 0, 0, 0);
        check("p_resume", 32'(bus.running), 32'h1);
        step(1, 0, 0, 0, 0);
        check("p_zero", digits(), 32'h0000);
        check("p_alarm", 32'(bus.alarm), 32'h1);
        check("p_done", 32'(bus.done), 32'h1);
        step(0, 1, 0, 0, 0);
        check("ack_alarm", 32'(bus.alarm), 32'h0);
        check("ack_running", 32'(bus.running), 32'h0);

        // Borrow 10:00 -> 09:59.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        check("set_1000", digits(), 32'h1000);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("borrow", digits(), 32'h0959);
        step(0, 0, 1, 0, 0);
        check("clr1", digits(), 32'h0000);

        // Seconds wrap without carry; minutes wrap at 99.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1);
        check("sec_59", digits(), 32'h0159);
        step(0, 0, 0, 0, 1);
        check("sec_wrap", digits(), 32'h0100);
        step(0, 0, 0, 1, 1);
        check("both_inc", digits(), 32'h0201);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 99; i++) step(0, 0, 0, 1, 0);
        check("min_99", digits(), 32'h9900);
        step(0, 0, 0, 1, 0);
        check("min_wrap", digits(), 32'h0000);

        // Start at 00:00 is ignored.
        step(0, 1, 0, 0, 0);
        check("start_zero", 32'(bus.running), 32'h0);

        // Pause and tick together at 00:30.
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("run_0030", 32'(bus.running), 32'h1);
        step(1, 1, 0, 0, 0);
        check("sp_tick_run", 32'(bus.running), 32'h0);
        check("sp_tick_val", digits(), 32'h0030);
        step(0, 0, 0, 1, 0);
        check("paused_inc_ign", digits(), 32'h0030);
        step(0, 0, 1, 0, 0);

        // Clear while running at 03:17.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("set_0317", digits(), 32'h0317);
        step(0, 0, 1, 0, 0);
        check("clr_run_val", digits(), 32'h0000);
        check("clr_run_state", 32'(bus.running), 32'h0);

        // Asynchronous reset mid-count at 05:42.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 42; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("set_0542", digits(), 32'h0542);
        #3;
        reset = 1'b1;
        #1;
        check("arst_digits", digits(), 32'h0000);
        check("arst_running", 32'(bus.running), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        check("post_rst_tick", digits(), 32'h0000);
        check("post_rst_idle", 32'(bus.running), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
